// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - RV32I memory-access stage with MEM/WB register; optional MEM_MISALIGN_TRAP_EN
module stage_mem (
    input  logic        clk,
    input  logic        rstn,
    input  logic        me_valid,
    input  logic [31:0] me_alu_o,
    input  logic [31:0] me_regs_data2,
    input  logic [2:0]  me_func3_code,
    input  logic        me_mem_read,
    input  logic        me_mem_write,
    input  logic        me_regs_write,
    input  logic        me_mem_to_reg,
    input  logic [4:0]  me_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        w_valid,
    output logic        w_regs_write,
    output logic        w_mem_to_reg,
    output logic [4:0]  w_rd,
    output logic [31:0] w_alu_o,
    output logic [31:0] w_mem_data,
    output logic        w_misalign
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_next;
    logic        access;
    logic        misalign;
    logic        req;
    logic        load_fire;
    logic [1:0]  o;
    logic        is_byte, is_half, ld_signed;
    logic [3:0]  be_raw;
    logic [31:0] wdata_raw;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign o         = me_alu_o[1:0];
    assign is_byte   = (me_func3_code[1:0] == 2'b00);
    assign is_half   = (me_func3_code[1:0] == 2'b01);
    assign ld_signed = ~me_func3_code[2];
    assign access    = me_valid & (me_mem_read | me_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = access & ((is_half & o[0]) | (~is_byte & ~is_half & (o != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // Request is gated by rstn so it drops the instant reset asserts, even mid-WAIT.
    assign req        = rstn & access & ~misalign;
    assign dmem_req   = req;
    assign dmem_we    = req & me_mem_write;
    assign dmem_addr  = req ? {me_alu_o[31:2], 2'b00} : 32'd0;
    assign dmem_be    = req ? be_raw : 4'd0;
    assign dmem_wdata = req ? wdata_raw : 32'd0;
    assign mem_stall  = req & ~dmem_ready;
    assign load_fire  = req & ~me_mem_write & dmem_ready;

    always_comb begin
        be_raw    = 4'b1111;
        wdata_raw = me_regs_data2;
        if (is_byte) begin
            be_raw    = 4'b0001 << o;
            wdata_raw = {4{me_regs_data2[7:0]}};
        end else if (is_half) begin
            be_raw    = 4'b0011 << {o[1], 1'b0};
            wdata_raw = {2{me_regs_data2[15:0]}};
        end
    end

    always_comb begin
        case (o)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = o[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (is_byte)
            ld_ext = {{24{ld_signed & ld_byte[7]}}, ld_byte};
        else if (is_half)
            ld_ext = {{16{ld_signed & ld_half[15]}}, ld_half};
        else
            ld_ext = dmem_rdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req && !dmem_ready) state_next = WAIT;
            WAIT:    if (!req || dmem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A stall inserts a bubble into WB while holding the payload fields.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_valid      <= 1'b0;
            w_regs_write <= 1'b0;
            w_mem_to_reg <= 1'b0;
            w_rd         <= 5'd0;
            w_alu_o      <= 32'd0;
            w_mem_data   <= 32'd0;
        end else if (mem_stall) begin
            w_valid      <= 1'b0;
            w_regs_write <= 1'b0;
        end else begin
            w_valid      <= me_valid;
            w_regs_write <= me_regs_write & ~misalign;
            w_mem_to_reg <= me_mem_to_reg;
            w_rd         <= me_rd;
            w_alu_o      <= me_alu_o;
            w_mem_data   <= load_fire ? ld_ext : 32'd0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)           w_misalign <= 1'b0;
        else if (!mem_stall) w_misalign <= misalign;
    end
`else
    assign w_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_stage_mem.sv
// tb/tb_stage_mem.sv - directed self-checking bench for stage_mem
module tb_stage_mem;

    logic        clk;
    logic        rstn;
    logic        me_valid;
    logic [31:0] me_alu_o;
    logic [31:0] me_regs_data2;
    logic [2:0]  me_func3_code;
    logic        me_mem_read;
    logic        me_mem_write;
    logic        me_regs_write;
    logic        me_mem_to_reg;
    logic [4:0]  me_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        w_valid;
    logic        w_regs_write;
    logic        w_mem_to_reg;
    logic [4:0]  w_rd;
    logic [31:0] w_alu_o;
    logic [31:0] w_mem_data;
    logic        w_misalign;

    int checks   = 0;
    int failures = 0;

    stage_mem dut (
        .clk           (clk),
        .rstn          (rstn),
        .me_valid      (me_valid),
        .me_alu_o      (me_alu_o),
        .me_regs_data2 (me_regs_data2),
        .me_func3_code (me_func3_code),
        .me_mem_read   (me_mem_read),
        .me_mem_write  (me_mem_write),
        .me_regs_write (me_regs_write),
        .me_mem_to_reg (me_mem_to_reg),
        .me_rd         (me_rd),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .mem_stall     (mem_stall),
        .w_valid       (w_valid),
        .w_regs_write  (w_regs_write),
        .w_mem_to_reg  (w_mem_to_reg),
        .w_rd          (w_rd),
        .w_alu_o       (w_alu_o),
        .w_mem_data    (w_mem_data),
        .w_misalign    (w_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] d2,
                         input logic [2:0] f3, input logic rd_en, input logic wr_en,
                         input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic rdy, input logic [31:0] rdata);
        me_valid      = v;
        me_alu_o      = alu;
        me_regs_data2 = d2;
        me_func3_code = f3;
        me_mem_read   = rd_en;
        me_mem_write  = wr_en;
        me_regs_write = rw;
        me_mem_to_reg = m2r;
        me_rd         = rd;
        dmem_ready    = rdy;
        dmem_rdata    = rdata;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(1'b1, 32'h100, 32'h1234, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF);
        #2;
        checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_wdata, mem_stall} !== 39'd0) begin
            failures++;
            $display("FAIL reset_dmem act req=%b we=%b be=%h wdata=%h stall=%b exp all 0",
                     dmem_req, dmem_we, dmem_be, dmem_wdata, mem_stall);
        end
        checks++;
        if ({w_valid, w_regs_write, w_mem_to_reg, w_rd, w_alu_o, w_mem_data, w_misalign} !== 73'd0) begin
            failures++;
            $display("FAIL reset_w act valid=%b rw=%b m2r=%b rd=%0d alu=%h data=%h mis=%b exp all 0",
                     w_valid, w_regs_write, w_mem_to_reg, w_rd, w_alu_o, w_mem_data, w_misalign);
        end
        tick();
        rstn = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_lw_zero_wait();
        drive(1'b1, 32'h100, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF);
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, mem_stall} !== {1'b1, 1'b0, 32'h100, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL lw_req act req=%b we=%b addr=%h be=%h stall=%b exp 1 0 00000100 f 0",
                     dmem_req, dmem_we, dmem_addr, dmem_be, mem_stall);
        end
        tick();
        checks++;
        if ({w_valid, w_regs_write, w_mem_to_reg, w_rd, w_alu_o, w_mem_data} !==
            {1'b1, 1'b1, 1'b1, 5'd5, 32'h100, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL lw_wb act valid=%b rw=%b m2r=%b rd=%0d alu=%h data=%h exp 1 1 1 5 00000100 deadbeef",
                     w_valid, w_regs_write, w_mem_to_reg, w_rd, w_alu_o, w_mem_data);
        end
    endtask

    task automatic test_load_extend();
        drive(1'b1, 32'h103, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 32'h8011_2233);
        #1;
        checks++;
        if (dmem_be !== 4'b1000) begin
            failures++;
            $display("FAIL lb_be act=%b exp=1000", dmem_be);
        end
        tick();
        checks++;
        if (w_mem_data !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL lb_data act=%h exp=ffffff80", w_mem_data);
        end
        drive(1'b1, 32'h103, 32'h0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 32'h8011_2233);
        tick();
        checks++;
        if (w_mem_data !== 32'h0000_0080) begin
            failures++;
            $display("FAIL lbu_data act=%h exp=00000080", w_mem_data);
        end
        drive(1'b1, 32'h102, 32'h0, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 32'h8011_2233);
        #1;
        checks++;
        if (dmem_be !== 4'b1100) begin
            failures++;
            $display("FAIL lh_be act=%b exp=1100", dmem_be);
        end
        tick();
        checks++;
        if (w_mem_data !== 32'hFFFF_8011) begin
            failures++;
            $display("FAIL lh_data act=%h exp=ffff8011", w_mem_data);
        end
        drive(1'b1, 32'h100, 32'h0, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 32'h8011_A233);
        tick();
        checks++;
        if (w_mem_data !== 32'h0000_A233) begin
            failures++;
            $display("FAIL lhu_data act=%h exp=0000a233", w_mem_data);
        end
    endtask

    task automatic test_store();
        drive(1'b1, 32'h202, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0);
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD}) begin
            failures++;
            $display("FAIL sh_port act req=%b we=%b addr=%h be=%b wdata=%h exp 1 1 00000200 1100 abcdabcd",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        drive(1'b1, 32'h201, 32'h1234_5678, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0);
        #1;
        checks++;
        if ({dmem_be, dmem_wdata} !== {4'b0010, 32'h7878_7878}) begin
            failures++;
            $display("FAIL sb_port act be=%b wdata=%h exp 0010 78787878", dmem_be, dmem_wdata);
        end
        // read and write both set: write must win
        drive(1'b1, 32'h204, 32'hCAFE_0001, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 32'h5555_5555);
        #1;
        checks++;
        if ({dmem_we, dmem_be, dmem_wdata} !== {1'b1, 4'hF, 32'hCAFE_0001}) begin
            failures++;
            $display("FAIL sw_rw_port act we=%b be=%h wdata=%h exp 1 f cafe0001", dmem_we, dmem_be, dmem_wdata);
        end
        tick();
    endtask

    task automatic test_wait();
        drive(1'b1, 32'h55, 32'h0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 32'h0);
        tick();
        drive(1'b1, 32'h300, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 32'hBAD0_BAD0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({mem_stall, dmem_req, dmem_addr} !== {1'b1, 1'b1, 32'h300}) begin
                failures++;
                $display("FAIL wait_stall%0d act stall=%b req=%b addr=%h exp 1 1 00000300",
                         i, mem_stall, dmem_req, dmem_addr);
            end
            tick();
            checks++;
            if ({w_valid, w_regs_write, w_alu_o, w_rd} !== {1'b0, 1'b0, 32'h55, 5'd9}) begin
                failures++;
                $display("FAIL wait_bubble%0d act valid=%b rw=%b alu=%h rd=%0d exp 0 0 00000055 9",
                         i, w_valid, w_regs_write, w_alu_o, w_rd);
            end
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL wait_done_stall act=%b exp=0", mem_stall);
        end
        tick();
        checks++;
        if ({w_valid, w_rd, w_mem_data} !== {1'b1, 5'd10, 32'h1234_5678}) begin
            failures++;
            $display("FAIL wait_result act valid=%b rd=%0d data=%h exp 1 10 12345678", w_valid, w_rd, w_mem_data);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h400, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 1'b1, 32'h1111_1111);
        tick();
        drive(1'b1, 32'h404, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 1'b1, 32'h0000_007F);
        #1;
        checks++;
        if ({dmem_req, dmem_addr, mem_stall} !== {1'b1, 32'h404, 1'b0}) begin
            failures++;
            $display("FAIL b2b_req act req=%b addr=%h stall=%b exp 1 00000404 0", dmem_req, dmem_addr, mem_stall);
        end
        tick();
        checks++;
        if ({w_valid, w_rd, w_mem_data} !== {1'b1, 5'd12, 32'h0000_007F}) begin
            failures++;
            $display("FAIL b2b_result act valid=%b rd=%0d data=%h exp 1 12 0000007f", w_valid, w_rd, w_mem_data);
        end
        drive(1'b0, 32'h500, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 1'b1, 32'hFFFF_FFFF);
        #1;
        checks++;
        if ({dmem_req, mem_stall} !== 2'b00) begin
            failures++;
            $display("FAIL idle_ready act req=%b stall=%b exp 0 0", dmem_req, mem_stall);
        end
        tick();
        checks++;
        if (w_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_wb act valid=%b exp 0", w_valid);
        end
    endtask

    task automatic test_reset_in_wait();
        drive(1'b1, 32'h600, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd14, 1'b0, 32'h0);
        tick();
        checks++;
        if ({dmem_req, mem_stall} !== 2'b11) begin
            failures++;
            $display("FAIL rstwait_pre act req=%b stall=%b exp 1 1", dmem_req, mem_stall);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({dmem_req, mem_stall, w_valid, w_regs_write, w_mem_to_reg, w_rd, w_alu_o, w_mem_data} !== 73'd0) begin
            failures++;
            $display("FAIL rstwait_async act req=%b stall=%b valid=%b rw=%b m2r=%b rd=%0d alu=%h data=%h exp all 0",
                     dmem_req, mem_stall, w_valid, w_regs_write, w_mem_to_reg, w_rd, w_alu_o, w_mem_data);
        end
        tick();
        rstn = 1'b1;
        drive(1'b1, 32'h700, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd15, 1'b1, 32'h0BAD_F00D);
        #1;
        checks++;
        if ({dmem_req, mem_stall} !== 2'b10) begin
            failures++;
            $display("FAIL rstwait_post act req=%b stall=%b exp 1 0", dmem_req, mem_stall);
        end
        tick();
        checks++;
        if ({w_valid, w_mem_data} !== {1'b1, 32'h0BAD_F00D}) begin
            failures++;
            $display("FAIL rstwait_result act valid=%b data=%h exp 1 0badf00d", w_valid, w_mem_data);
        end
    endtask

    task automatic test_misalign();
        drive(1'b1, 32'h101, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd16, 1'b0, 32'hCAFE_F00D);
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        checks++;
        if ({dmem_req, mem_stall} !== 2'b00) begin
            failures++;
            $display("FAIL mis_trap_req act req=%b stall=%b exp 0 0", dmem_req, mem_stall);
        end
        tick();
        checks++;
        if ({w_misalign, w_valid, w_regs_write} !== 3'b110) begin
            failures++;
            $display("FAIL mis_trap_wb act mis=%b valid=%b rw=%b exp 1 1 0", w_misalign, w_valid, w_regs_write);
        end
`else
        dmem_ready = 1'b1;
        #1;
        checks++;
        if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, 32'h100, 4'hF}) begin
            failures++;
            $display("FAIL mis_align_req act req=%b addr=%h be=%h exp 1 00000100 f", dmem_req, dmem_addr, dmem_be);
        end
        tick();
        checks++;
        if ({w_misalign, w_valid, w_regs_write, w_mem_data} !== {3'b011, 32'hCAFE_F00D}) begin
            failures++;
            $display("FAIL mis_align_wb act mis=%b valid=%b rw=%b data=%h exp 0 1 1 cafef00d",
                     w_misalign, w_valid, w_regs_write, w_mem_data);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_load_extend();
        test_store();
        test_wait();
        test_back_to_back();
        test_reset_in_wait();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
